// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage owning the PC and the IF/ID register, with stall, redirect and bubble insertion.
module fetch_stage #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] if_id_instr,
  output logic [WIDTH-1:0] if_id_pc_plus4,
  output logic             if_id_valid
);
  logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pp4_q, pp4_d, pc_plus4, target;
  logic valid_q, valid_d, redirect;
  always_comb begin
    pc_plus4 = pc_q + WIDTH'(4);
    redirect = jump | branch_taken;
    target   = (jump ? jump_target : branch_target) & ~WIDTH'(3);
    pc_d     = stall ? pc_q : redirect ? target : pc_plus4;
    instr_d  = stall ? instr_q : redirect ? NOP : instr_in;
    pp4_d    = stall ? pp4_q : redirect ? '0 : pc_plus4;
    valid_d  = stall ? valid_q : !redirect;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pp4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pp4_q;
  assign if_id_valid    = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan checks plus randomized run against a behavioural fetch model.
module tb_fetch_stage;
  logic clk = 1'b0, rst, stall, branch_taken, jump, if_id_valid;
  logic [31:0] branch_target, jump_target, instr_in, pc, if_id_instr, if_id_pc_plus4;
  logic [31:0] m_pc, m_instr, m_pp4;
  logic m_valid;
  logic chk_en = 1'b0;
  int vectors = 0, miscompares = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .instr_in(instr_in), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a < 32'd16) return 32'h1111_1111 * ({30'd0, a[3:2]} + 32'd1);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign instr_in = imem(pc);

  // Reference: each edge applies the first matching rule of reset, stall, redirect, sequential fetch.
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'd0; m_instr <= 32'd0; m_pp4 <= 32'd0; m_valid <= 1'b0;
    end else if (!stall) begin
      if (jump || branch_taken) begin
        m_pc <= (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        m_instr <= 32'd0; m_pp4 <= 32'd0; m_valid <= 1'b0;
      end else begin
        m_pc <= m_pc + 32'd4; m_instr <= imem(m_pc); m_pp4 <= m_pc + 32'd4; m_valid <= 1'b1;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("pc", pc, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
  end

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    rst = r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    @(negedge clk);
  endtask

  task automatic pin(input string n, input logic [31:0] p, input logic [31:0] i,
                     input logic [31:0] p4, input logic v);
    chk({n, "_pc"}, pc, p);
    chk({n, "_instr"}, if_id_instr, i);
    chk({n, "_pp4"}, if_id_pc_plus4, p4);
    chk({n, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    pin("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    pin("fetch0", 32'h4, 32'h1111_1111, 32'h4, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    pin("fetch1", 32'h8, 32'h2222_2222, 32'h8, 1'b1);
    repeat (3) drive(0, 1, 0, 0, 0, 0);
    pin("stall", 32'h8, 32'h2222_2222, 32'h8, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    pin("resume", 32'hC, 32'h3333_3333, 32'hC, 1'b1);
    drive(0, 0, 1, 32'h42, 0, 0);
    pin("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    pin("target", 32'h44, imem(32'h40), 32'h44, 1'b1);
    drive(0, 1, 1, 32'h40, 1, 32'h80);
    chk("stall_redirect_pc", pc, 32'h44);
    drive(0, 0, 1, 32'h40, 1, 32'h80);
    chk("jump_wins_pc", pc, 32'h80);
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("jump_top_pc", pc, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0);
    pin("wrap", 32'h0, imem(32'hFFFF_FFFC), 32'h0, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'h100, 0, 0);
    drive(1, 1, 1, 32'h100, 0, 0);
    pin("rst_in_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] bt, jt;
      bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      jt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, bt,
            $urandom_range(0, 5) == 0, jt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter, drives the combinational instruction memory address, and captures the fetched word into the IF/ID pipeline register. It applies stall and redirect (branch/jump) control from the decode stage and hazard unit, and inserts a NOP bubble on every redirect.

## Interface
- WIDTH, 32, data/address width; PC and instructions are WIDTH bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP, 32'h0000_0000, instruction word inserted on flush/reset (sll $0,$0,0).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit hold: freeze PC and IF/ID.
- branch_taken  in  1  ID-stage branch resolved taken.
- branch_target  in  WIDTH  branch destination byte address.
- jump  in  1  ID-stage unconditional jump.
- jump_target  in  WIDTH  jump destination byte address.
- instr_in  in  WIDTH  word returned by instruction memory for pc (combinational).
- pc  out  WIDTH  current fetch address, to instruction memory.
- if_id_instr  out  WIDTH  registered instruction for decode.
- if_id_pc_plus4  out  WIDTH  registered pc+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.

## Operation
- pc_plus4 = pc + 4, modulo 2^WIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
- Targets are forced word-aligned: bits [1:0] of branch_target/jump_target are ignored and replaced with 2'b00. pc[1:0] is always 0.
- Per-edge priority, highest first:
  1. rst: pc <= RESET_PC; if_id_instr <= NOP; if_id_pc_plus4 <= 0; if_id_valid <= 0.
  2. stall: pc, if_id_instr, if_id_pc_plus4, if_id_valid all hold. Redirect inputs are ignored in this cycle; the hazard unit re-presents them once the stall clears.
  3. jump (takes precedence over branch_taken): pc <= jump_target; IF/ID loads NOP, pc_plus4 = 0, valid 0.
  4. branch_taken: pc <= branch_target; IF/ID flushed as in 3.
  5. normal: pc <= pc_plus4; if_id_instr <= instr_in; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1.
- Internal state: the PC register and the IF/ID register only. No FSM beyond the priority mux. No combinational path from any input to pc.

## Timing
- Reset values: pc = RESET_PC, if_id_instr = NOP, if_id_pc_plus4 = 0, if_id_valid = 0. rst asserted mid-stream overrides stall and redirect on the same edge.
- Fetch latency: the word at address A (pc = A during cycle n) appears on if_id_instr after edge n+1, with if_id_pc_plus4 = A+4.
- Redirect penalty: one bubble. A redirect sampled at edge n makes pc = target after n; the target instruction reaches IF/ID after n+1. The slot fetched during the redirect cycle is discarded.
- Stall: holds for as many cycles as asserted. The first non-stalled edge resumes from the held pc with no lost or duplicated instruction.
- Simultaneous events: jump and branch_taken together → jump wins. Stall and redirect together → stall wins, redirect dropped.

## Test plan
- Reset then free-run with imem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444 → pc = 0,4,8,12. IF/ID shows 0x11111111/pc+4 = 4, then 0x22222222/8, valid 1 from the second edge.
- Stall asserted for 3 cycles at pc = 8 → pc stays 8 and IF/ID holds 0x22222222/8. After release: 0x33333333/12, no duplicate.
- branch_taken with branch_target = 0x0000_0042 at pc = 12 → next pc = 0x40, one IF/ID bubble (valid 0, NOP), then imem[0x10]/0x44.
- jump = 1 with jump_target = 0x80 and branch_taken = 1 with target 0x40 on the same edge → pc = 0x80. Same request with stall = 1 → pc unchanged.
- pc forced to 0xFFFF_FFFC via jump, run → pc wraps to 0 and if_id_pc_plus4 = 0.
- rst pulsed during a stall with pending branch → pc = RESET_PC, IF/ID = NOP/0/valid 0 on that edge.
